// File: rtl/axis_sync_fifo.sv
// Synchronous FIFO for the AXIS packetizer: registered read/write pointers with one wrap bit,
// combinational read of the head entry, and a write that is allowed into a full FIFO when a read happens in the same cycle.
module axis_sync_fifo #(
  parameter int WIDTH = 1025,
  parameter int DEPTH = 32,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int PTR_W  = ADDR_W + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [PTR_W-1:0] level_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             wr_ok, rd_ok;

  assign level_o   = wr_ptr_q - rd_ptr_q;
  assign full_o    = (level_o == PTR_W'(DEPTH));
  assign empty_o   = (level_o == '0);
  assign rd_data_o = mem_q[rd_ptr_q[ADDR_W-1:0]];

  // When full, the slot being written is the one being read; the read sees the old entry.
  assign rd_ok = rd_en_i && !empty_o;
  assign wr_ok = wr_en_i && (!full_o || rd_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (rd_ok) rd_ptr_d = rd_ptr_q + PTR_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_ok) mem_q[wr_ptr_q[ADDR_W-1:0]] <= wr_data_i;
  end

endmodule

// File: rtl/data_to_axis_packetizer.sv
// Trace-item packetizer: buffers one item per cycle, generates tlast from an interval counter or force input,
// counts dropped items on overflow, and streams items out through a single AXIS output register.
module data_to_axis_packetizer #(
  parameter int DATA_WIDTH = 1024,
  parameter int FIFO_DEPTH = 32,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          write_enable,
  input  logic [DATA_WIDTH-1:0]         data_pkt,
  input  logic                          force_tlast,
  input  logic [CNT_WIDTH-1:0]          tlast_interval,
  input  logic                          flush,
  output logic                          M_AXIS_tvalid,
  input  logic                          M_AXIS_tready,
  output logic [DATA_WIDTH-1:0]         M_AXIS_tdata,
  output logic                          M_AXIS_tlast,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [CNT_WIDTH-1:0]          drop_count,
  output logic                          overflow
);

  localparam int ADDR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W  = ADDR_W + 1;

  logic                  fifo_full, fifo_empty;
  logic [DATA_WIDTH:0]   fifo_rdata;
  logic [LVL_W-1:0]      fifo_lvl;
  logic                  pop, push, drop, interval_hit, tlast_in;

  logic [CNT_WIDTH-1:0]  pkt_cnt_q, pkt_cnt_d;
  logic [CNT_WIDTH-1:0]  drop_cnt_q, drop_cnt_d;
  logic                  pending_q, pending_d;
  logic                  overflow_q, overflow_d;
  logic                  tvalid_q, tvalid_d;
  logic                  tlast_q, tlast_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;

  // AXIS handshake: a beat transfers on a rising edge where tvalid and tready are both high; once tvalid
  // is raised, tdata/tlast hold and tvalid stays high until that transfer (reset and flush excepted).
  assign pop  = (!tvalid_q || M_AXIS_tready) && !fifo_empty;
  assign push = write_enable && (!fifo_full || pop);
  assign drop = write_enable && !push;

  // A counter already at or past the new boundary closes the packet on the next push.
  assign interval_hit = (tlast_interval != '0) &&
                        (pkt_cnt_q >= tlast_interval - CNT_WIDTH'(1));
  assign tlast_in     = force_tlast || pending_q || interval_hit;

  axis_sync_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .clr_i     (flush),
    .wr_en_i   (push),
    .wr_data_i ({tlast_in, data_pkt}),
    .rd_en_i   (pop),
    .rd_data_o (fifo_rdata),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .level_o   (fifo_lvl)
  );

  always_comb begin
    pkt_cnt_d  = pkt_cnt_q;
    drop_cnt_d = drop_cnt_q;
    pending_d  = pending_q;
    overflow_d = overflow_q;
    tvalid_d   = tvalid_q;
    tlast_d    = tlast_q;
    tdata_d    = tdata_q;

    if (push) begin
      pkt_cnt_d = tlast_in ? '0 : pkt_cnt_q + CNT_WIDTH'(1);
      pending_d = 1'b0;
    end else if (drop) begin
      // Remember a lost packet end so the next accepted item closes the packet.
      pending_d  = pending_q || tlast_in;
      overflow_d = 1'b1;
      if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + CNT_WIDTH'(1);
    end

    if (pop) begin
      tvalid_d = 1'b1;
      tdata_d  = fifo_rdata[DATA_WIDTH-1:0];
      tlast_d  = fifo_rdata[DATA_WIDTH];
    end else if (!tvalid_q || M_AXIS_tready) begin
      tvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      pkt_cnt_q  <= '0;
      drop_cnt_q <= '0;
      pending_q  <= 1'b0;
      overflow_q <= 1'b0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      tdata_q    <= '0;
    end else begin
      pkt_cnt_q  <= pkt_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      tvalid_q   <= tvalid_d;
      tlast_q    <= tlast_d;
      tdata_q    <= tdata_d;
    end
  end

  assign M_AXIS_tvalid = tvalid_q;
  assign M_AXIS_tdata  = tdata_q;
  assign M_AXIS_tlast  = tlast_q;
  assign fifo_level    = fifo_lvl;
  assign drop_count    = drop_cnt_q;
  assign overflow      = overflow_q;

endmodule

// File: tb/tb_data_to_axis_packetizer.sv
// Bench for data_to_axis_packetizer: directed scenarios plus a long randomized run, all checked
// against a queue-based reference model of items in flight.
module tb_data_to_axis_packetizer;

  localparam int DW    = 64;
  localparam int DEPTH = 32;
  localparam int CW    = 32;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          write_enable;
  logic [DW-1:0] data_pkt;
  logic          force_tlast;
  logic [CW-1:0] tlast_interval;
  logic          flush;
  logic          M_AXIS_tvalid;
  logic          M_AXIS_tready;
  logic [DW-1:0] M_AXIS_tdata;
  logic          M_AXIS_tlast;
  logic [LW-1:0] fifo_level;
  logic [CW-1:0] drop_count;
  logic          overflow;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Reference model: items in the FIFO, the output register, packet state and drop accounting.
  logic [DW:0]   m_fifo [$];
  logic          m_valid;
  logic [DW:0]   m_item;
  logic [CW-1:0] m_cnt;
  logic          m_pend;
  logic [CW-1:0] m_drops;
  logic          m_ovf;

  // Beats observed on the DUT output, {tlast, tdata}, and the cycle each one transferred.
  logic [DW:0] got_q [$];
  int          got_cyc [$];

  data_to_axis_packetizer #(
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (DEPTH),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .write_enable   (write_enable),
    .data_pkt       (data_pkt),
    .force_tlast    (force_tlast),
    .tlast_interval (tlast_interval),
    .flush          (flush),
    .M_AXIS_tvalid  (M_AXIS_tvalid),
    .M_AXIS_tready  (M_AXIS_tready),
    .M_AXIS_tdata   (M_AXIS_tdata),
    .M_AXIS_tlast   (M_AXIS_tlast),
    .fifo_level     (fifo_level),
    .drop_count     (drop_count),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    m_fifo.delete();
    m_valid = 1'b0;
    m_item  = '0;
    m_cnt   = '0;
    m_pend  = 1'b0;
    m_drops = '0;
    m_ovf   = 1'b0;
  endtask

  task automatic model_edge(input logic we, input logic [DW-1:0] d, input logic ft,
                            input logic rdy, input logic fl);
    logic pop, acc, tl;
    if (!rst_n || fl) begin
      model_clear();
    end else begin
      pop = (!m_valid || rdy) && (m_fifo.size() > 0);
      tl  = ft || m_pend || ((tlast_interval != 0) && (m_cnt >= tlast_interval - 1));
      acc = we && ((m_fifo.size() < DEPTH) || pop);
      if (pop) begin
        m_item  = m_fifo.pop_front();
        m_valid = 1'b1;
      end else if (!m_valid || rdy) begin
        m_valid = 1'b0;
      end
      if (acc) begin
        m_fifo.push_back({tl, d});
        m_cnt  = tl ? '0 : m_cnt + 1;
        m_pend = 1'b0;
      end else if (we) begin
        if (m_drops != '1) m_drops = m_drops + 1;
        m_ovf = 1'b1;
        if (tl) m_pend = 1'b1;
      end
    end
  endtask

  // Drive one cycle's inputs, log any DUT handshake, advance the model, and stop 1 ns past the edge.
  task automatic step(input logic we, input logic [DW-1:0] d, input logic ft,
                      input logic rdy, input logic fl);
    write_enable  = we;
    data_pkt      = d;
    force_tlast   = ft;
    M_AXIS_tready = rdy;
    flush         = fl;
    if (rst_n && !fl && M_AXIS_tvalid && rdy) begin
      got_q.push_back({M_AXIS_tlast, M_AXIS_tdata});
      got_cyc.push_back(cyc);
    end
    model_edge(we, d, ft, rdy, fl);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, rdy, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    got_q.delete();
    got_cyc.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(1'($urandom), {$urandom, $urandom}, 1'($urandom), 1'($urandom), 1'b0);
    rst_n = 1'b1;
    tests++;
    if ({M_AXIS_tvalid, M_AXIS_tlast, M_AXIS_tdata} !== '0) begin
      fails++;
      $display("FAIL reset_axis: got valid=%b last=%b data=%h, want all 0",
               M_AXIS_tvalid, M_AXIS_tlast, M_AXIS_tdata);
    end
    tests++;
    if (fifo_level !== '0 || drop_count !== '0 || overflow !== 1'b0) begin
      fails++;
      $display("FAIL reset_status: got level=%0d drops=%0d ovf=%b, want 0 0 0",
               fifo_level, drop_count, overflow);
    end
    got_q.delete();
    got_cyc.delete();
  endtask

  task automatic test_interval();
    tlast_interval = 4;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(1'b1, DW'(i), 1'b0, 1'b1, 1'b0);
      if (i == 0) begin
        tests++;
        if (M_AXIS_tvalid !== 1'b0) begin
          fails++;
          $display("FAIL interval_latency0: tvalid=%b right after first push, want 0", M_AXIS_tvalid);
        end
      end
      tests++;
      if ({M_AXIS_tvalid, M_AXIS_tlast, M_AXIS_tdata} !== {m_valid, m_item} ||
          fifo_level !== LW'(m_fifo.size())) begin
        fails++;
        $display("FAIL interval_cycle%0d: got v=%b l=%b d=%h lvl=%0d, want v=%b l=%b d=%h lvl=%0d",
                 i, M_AXIS_tvalid, M_AXIS_tlast, M_AXIS_tdata, fifo_level,
                 m_valid, m_item[DW], m_item[DW-1:0], m_fifo.size());
      end
    end
    idle(4, 1'b1);
    tests++;
    if (got_q.size() != 10) begin
      fails++;
      $display("FAIL interval_count: got %0d beats, want 10", got_q.size());
    end else begin
      for (int i = 0; i < 10; i++) begin
        tests++;
        if (got_q[i] !== {(i == 3 || i == 7), DW'(i)} || got_cyc[i] != got_cyc[0] + i) begin
          fails++;
          $display("FAIL interval_beat%0d: got last=%b data=%h cyc+%0d, want last=%b data=%0d cyc+%0d",
                   i, got_q[i][DW], got_q[i][DW-1:0], got_cyc[i] - got_cyc[0], (i == 3 || i == 7), i, i);
        end
      end
    end
  endtask

  task automatic test_force();
    logic [4:0] exp_last;
    exp_last = 5'b10100;
    tlast_interval = 0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      if (i == 3) tlast_interval = 2;
      step(1'b1, DW'(100 + i), (i == 2), 1'b1, 1'b0);
    end
    idle(4, 1'b1);
    tests++;
    if (got_q.size() != 5) begin
      fails++;
      $display("FAIL force_count: got %0d beats, want 5", got_q.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        tests++;
        if (got_q[i] !== {exp_last[i], DW'(100 + i)}) begin
          fails++;
          $display("FAIL force_beat%0d: got last=%b data=%0d, want last=%b data=%0d",
                   i, got_q[i][DW], got_q[i][DW-1:0], exp_last[i], 100 + i);
        end
      end
    end
  endtask

  task automatic test_overflow();
    tlast_interval = 0;
    do_reset();
    for (int i = 0; i < 40; i++) step(1'b1, DW'(i), 1'b0, 1'b0, 1'b0);
    tests++;
    if (fifo_level !== LW'(32) || drop_count !== CW'(7) || overflow !== 1'b1) begin
      fails++;
      $display("FAIL overflow_status: got level=%0d drops=%0d ovf=%b, want 32 7 1",
               fifo_level, drop_count, overflow);
    end
    tests++;
    if (M_AXIS_tvalid !== 1'b1 || M_AXIS_tdata !== DW'(0)) begin
      fails++;
      $display("FAIL overflow_outreg: got v=%b d=%0d, want v=1 d=0", M_AXIS_tvalid, M_AXIS_tdata);
    end
    idle(40, 1'b1);
    tests++;
    if (got_q.size() != 33) begin
      fails++;
      $display("FAIL overflow_count: got %0d beats, want 33", got_q.size());
    end
    for (int i = 0; i < got_q.size(); i++) begin
      tests++;
      if (got_q[i][DW-1:0] !== DW'(i)) begin
        fails++;
        $display("FAIL overflow_order%0d: got data=%0d, want %0d", i, got_q[i][DW-1:0], i);
      end
    end
  endtask

  task automatic test_full_push_pop();
    tlast_interval = 0;
    do_reset();
    for (int i = 0; i < 33; i++) step(1'b1, DW'(i), 1'b0, 1'b0, 1'b0);
    tests++;
    if (fifo_level !== LW'(32)) begin
      fails++;
      $display("FAIL fullpp_fill: got level=%0d, want 32", fifo_level);
    end
    got_q.delete();
    step(1'b1, DW'(500), 1'b0, 1'b1, 1'b0);
    tests++;
    if (fifo_level !== LW'(32) || drop_count !== '0 || overflow !== 1'b0) begin
      fails++;
      $display("FAIL fullpp_accept: got level=%0d drops=%0d ovf=%b, want 32 0 0",
               fifo_level, drop_count, overflow);
    end
    idle(40, 1'b1);
    tests++;
    if (got_q.size() != 34 || got_q[got_q.size()-1][DW-1:0] !== DW'(500)) begin
      fails++;
      $display("FAIL fullpp_drain: got %0d beats, want 34 ending with 500", got_q.size());
    end
  endtask

  task automatic test_drop_tlast();
    logic [3:0] exp_last;
    exp_last = 4'b1001;
    tlast_interval = 3;
    do_reset();
    step(1'b1, DW'(0), 1'b1, 1'b0, 1'b0);
    for (int i = 1; i < 33; i++) step(1'b1, DW'(i), 1'b0, 1'b0, 1'b0);
    step(1'b1, DW'(900), 1'b0, 1'b0, 1'b0);
    step(1'b1, DW'(901), 1'b0, 1'b0, 1'b0);
    tests++;
    if (drop_count !== CW'(2) || overflow !== 1'b1) begin
      fails++;
      $display("FAIL droptl_drops: got drops=%0d ovf=%b, want 2 1", drop_count, overflow);
    end
    for (int i = 0; i < 4; i++) step(1'b1, DW'(600 + i), 1'b0, 1'b1, 1'b0);
    idle(40, 1'b1);
    tests++;
    if (got_q.size() != 37) begin
      fails++;
      $display("FAIL droptl_count: got %0d beats, want 37", got_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests++;
        if (got_q[33+i] !== {exp_last[i], DW'(600 + i)}) begin
          fails++;
          $display("FAIL droptl_beat%0d: got last=%b data=%0d, want last=%b data=%0d",
                   i, got_q[33+i][DW], got_q[33+i][DW-1:0], exp_last[i], 600 + i);
        end
      end
    end
  endtask

  task automatic test_flush(input bit use_reset);
    tlast_interval = 0;
    do_reset();
    for (int i = 0; i < 35; i++) step(1'b1, DW'(i), 1'b0, 1'b0, 1'b0);
    idle(28, 1'b1);
    tests++;
    if (fifo_level !== LW'(4) || drop_count !== CW'(2) || M_AXIS_tvalid !== 1'b1) begin
      fails++;
      $display("FAIL flush%0d_pre: got level=%0d drops=%0d v=%b, want 4 2 1",
               use_reset, fifo_level, drop_count, M_AXIS_tvalid);
    end
    if (use_reset) begin
      rst_n = 1'b0;
      step(1'b1, DW'(777), 1'b0, 1'b1, 1'b0);
      rst_n = 1'b1;
    end else begin
      step(1'b1, DW'(777), 1'b0, 1'b1, 1'b1);
    end
    tests++;
    if (M_AXIS_tvalid !== 1'b0 || fifo_level !== '0 || drop_count !== '0 || overflow !== 1'b0 ||
        M_AXIS_tdata !== '0 || M_AXIS_tlast !== 1'b0) begin
      fails++;
      $display("FAIL flush%0d_clear: got v=%b lvl=%0d drops=%0d ovf=%b d=%h l=%b, want all 0",
               use_reset, M_AXIS_tvalid, fifo_level, drop_count, overflow, M_AXIS_tdata, M_AXIS_tlast);
    end
    got_q.delete();
    tlast_interval = 3;
    for (int i = 0; i < 3; i++) step(1'b1, DW'(40 + i), 1'b0, 1'b1, 1'b0);
    idle(4, 1'b1);
    tests++;
    if (got_q.size() != 3 || got_q[0] !== {1'b0, DW'(40)} || got_q[1] !== {1'b0, DW'(41)} ||
        got_q[2] !== {1'b1, DW'(42)}) begin
      fails++;
      $display("FAIL flush%0d_restart: got %0d beats, want 40,41,42 with tlast on 42 only",
               use_reset, got_q.size());
    end
  endtask

  task automatic test_random();
    int rdy_pct;
    logic fl;
    rdy_pct = 70;
    tlast_interval = 3;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) rdy_pct = $urandom_range(5, 100);
      if ($urandom_range(0, 99) == 0) tlast_interval = CW'($urandom_range(0, 5));
      fl = ($urandom_range(0, 299) == 0);
      step(($urandom_range(0, 3) != 0), {$urandom, $urandom}, ($urandom_range(0, 15) == 0),
           ($urandom_range(1, 100) <= rdy_pct), fl);
      tests++;
      if ({M_AXIS_tvalid, M_AXIS_tlast, M_AXIS_tdata} !== {m_valid, m_item} ||
          fifo_level !== LW'(m_fifo.size()) || drop_count !== m_drops || overflow !== m_ovf) begin
        fails++;
        $display("FAIL random_c%0d: got v=%b l=%b d=%h lvl=%0d drops=%0d ovf=%b, want v=%b l=%b d=%h lvl=%0d drops=%0d ovf=%b",
                 c, M_AXIS_tvalid, M_AXIS_tlast, M_AXIS_tdata, fifo_level, drop_count, overflow,
                 m_valid, m_item[DW], m_item[DW-1:0], m_fifo.size(), m_drops, m_ovf);
      end
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    write_enable   = 1'b0;
    data_pkt       = '0;
    force_tlast    = 1'b0;
    tlast_interval = '0;
    flush          = 1'b0;
    M_AXIS_tready  = 1'b0;
    model_clear();
    test_reset();
    test_interval();
    test_force();
    test_overflow();
    test_full_push_pop();
    test_drop_tlast();
    test_flush(1'b0);
    test_flush(1'b1);
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
